// File: rtl/box_downsampler_if.sv
// Pixel-stream bundle for the 2x2 box decimator.
// The slave side is the decimator; the master side is whoever drives it.
interface box_downsampler_if;
    logic       valid;
    logic [7:0] data;
    logic       sof;
    logic [7:0] dataout;
    logic       validout;
    logic       sof_out;

    modport master (
        output valid,
        output data,
        output sof,
        input  dataout,
        input  validout,
        input  sof_out
    );

    modport slave (
        input  valid,
        input  data,
        input  sof,
        output dataout,
        output validout,
        output sof_out
    );
endinterface

// File: rtl/box_downsampler.sv
// 2x2 box-filter decimator: each output pixel is the half-up rounded mean of
// one 2x2 block of a raster-order 8-bit stream, emitted one cycle after its last pixel.
module box_downsampler #(
    parameter int IN_WIDTH  = 800,
    parameter int IN_HEIGHT = 600,
    parameter int CNT_W     = 10
) (
    input  logic              clock,
    input  logic              reset,
    box_downsampler_if.slave  bus
);

    localparam int LB_DEPTH = IN_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IN_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IN_HEIGHT - 1);

    // Rounded mean of two 9-bit horizontal pair sums; the 10-bit total never overflows.
    function automatic logic [7:0] round_mean4(input logic [8:0] upper, input logic [8:0] lower);
        logic [9:0] total;
        total = {1'b0, upper} + {1'b0, lower} + 10'd2;
        return total[9:2];
    endfunction

    logic [CNT_W-1:0] col_r;
    logic [CNT_W-1:0] row_r;
    logic [7:0]       pair_r;
    logic [7:0]       dataout_r;
    logic             validout_r;
    logic             sof_out_r;
    logic [8:0]       linebuf_r [0:LB_DEPTH-1];

    logic [CNT_W-1:0] col_eff_s;
    logic [CNT_W-1:0] row_eff_s;
    logic [CNT_W-1:0] col_next_s;
    logic [CNT_W-1:0] row_next_s;
    logic [8:0]       hsum_s;
    logic [8:0]       lb_rd_s;
    logic [LB_AW-1:0] lb_idx_s;
    logic             odd_col_s;
    logic             odd_row_s;
    logic             first_block_s;

    // Effective pixel position (sof forces 0,0), next counter values and datapath sums.
    always_comb begin
        col_eff_s     = col_r;
        row_eff_s     = row_r;
        col_next_s    = col_r;
        row_next_s    = row_r;
        if (bus.valid && bus.sof) begin
            col_eff_s = {CNT_W{1'b0}};
            row_eff_s = {CNT_W{1'b0}};
        end else begin
            col_eff_s = col_r;
            row_eff_s = row_r;
        end
        if (col_eff_s == COL_LAST) begin
            col_next_s = {CNT_W{1'b0}};
            if (row_eff_s == ROW_LAST) begin
                row_next_s = {CNT_W{1'b0}};
            end else begin
                row_next_s = row_eff_s + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            col_next_s = col_eff_s + {{(CNT_W-1){1'b0}}, 1'b1};
            row_next_s = row_eff_s;
        end
        odd_col_s     = col_eff_s[0];
        odd_row_s     = row_eff_s[0];
        first_block_s = (row_eff_s == {{(CNT_W-1){1'b0}}, 1'b1}) &&
                        (col_eff_s == {{(CNT_W-1){1'b0}}, 1'b1});
        hsum_s        = {1'b0, pair_r} + {1'b0, bus.data};
        lb_idx_s      = col_eff_s[LB_AW:1];
        lb_rd_s       = linebuf_r[lb_idx_s];
    end

    // Position counters, horizontal pair register and registered output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_r      <= {CNT_W{1'b0}};
            row_r      <= {CNT_W{1'b0}};
            pair_r     <= 8'd0;
            dataout_r  <= 8'd0;
            validout_r <= 1'b0;
            sof_out_r  <= 1'b0;
        end else if (bus.valid) begin
            col_r <= col_next_s;
            row_r <= row_next_s;
            if (!odd_col_s) begin
                pair_r <= bus.data;
            end else begin
                pair_r <= pair_r;
            end
            if (odd_col_s && odd_row_s) begin
                dataout_r  <= round_mean4(lb_rd_s, hsum_s);
                validout_r <= 1'b1;
                sof_out_r  <= first_block_s;
            end else begin
                dataout_r  <= dataout_r;
                validout_r <= 1'b0;
                sof_out_r  <= 1'b0;
            end
        end else begin
            col_r      <= col_r;
            row_r      <= row_r;
            pair_r     <= pair_r;
            dataout_r  <= dataout_r;
            validout_r <= 1'b0;
            sof_out_r  <= 1'b0;
        end
    end

    // Line buffer of even-row pair sums; odd rows only read it, so no reset is needed.
    always_ff @(posedge clock) begin
        if (bus.valid && odd_col_s && !odd_row_s) begin
            linebuf_r[lb_idx_s] <= hsum_s;
        end else begin
            linebuf_r[lb_idx_s] <= linebuf_r[lb_idx_s];
        end
    end

    assign bus.dataout  = dataout_r;
    assign bus.validout = validout_r;
    assign bus.sof_out  = sof_out_r;

endmodule

// File: doc/box_downsampler.md
Name: box_downsampler

Overview:
2x2 box-filter decimator. Takes a raster-order 8-bit pixel stream, by default 800x600, and emits a half-resolution stream, by default 400x300. Each output pixel is the rounded mean of one 2x2 input block. It sits directly upstream of the pyramid FIFO, so the upsampler reads what this block writes. Its output valid drives the FIFO write enable.

Parameters:
IN_WIDTH, 800, input pixels per row; must be even.
IN_HEIGHT, 600, input rows per frame; must be even.
CNT_W, 10, width of the column and row counters; must satisfy 2^CNT_W > max(IN_WIDTH, IN_HEIGHT).

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
valid  input  1  data and sof are meaningful this cycle; no backpressure exists.
data  input  8  input pixel.
sof  input  1  start of frame; qualified by valid; marks pixel (0,0).
dataout  output  8  decimated pixel; registered.
validout  output  1  dataout is valid this cycle; used as the FIFO write enable.
sof_out  output  1  high together with validout for output pixel (0,0).

Behaviour:
- Single clock. Reset is synchronous and active-high. On reset: colcount=0, rowcount=0, pair_reg=0, dataout=0, validout=0, sof_out=0. Line-buffer contents are not reset.
- Input is accepted on every cycle where valid=1. Bubbles (valid=0) are allowed at any position, including mid-row. Counters and registers hold during a bubble.
- Counters, on an accepted pixel:
  - col increments.
  - When col==IN_WIDTH-1: col->0 and row increments.
  - When row==IN_HEIGHT-1 and col==IN_WIDTH-1: row->0.
- sof handling: if sof=1 with valid=1, the pixel is treated as (0,0) regardless of the counters. After that pixel, col=1 and row=0. A partial block from the interrupted frame is discarded. sof while valid=0 is ignored.
- Even col: pair_reg <= data.
- Odd col: hsum = pair_reg + data, 9 bits, no overflow.
- Even row, odd col: linebuf[col>>1] <= hsum. The line buffer is IN_WIDTH/2 x 9 bits and may be implemented as distributed RAM or BRAM.
- Odd row, odd col:
  - out = (linebuf[col>>1] + hsum + 2) >> 2, using a 10-bit sum.
  - The result is at most 255, so no saturation logic is needed.
  - Rounding is half-up.
- No read/write collision is possible: even rows only write the line buffer, odd rows only read it.
- Latency: dataout/validout are asserted exactly 1 cycle after the odd-row/odd-col input pixel is accepted. If the chosen RAM has a registered read, the address is issued one pixel early (at the even col) so that 1-cycle latency is preserved.
- Output rate:
  - validout is a 1-cycle pulse per output pixel.
  - There is at most one pulse per 2 input cycles.
  - Output per frame is exactly (IN_WIDTH/2)*(IN_HEIGHT/2) pulses.
- When validout=0, dataout holds its last value.
- sof_out=1 only with the validout pulse for input block (row 0-1, col 0-1) of a frame.
- Reset mid-frame: the output stage clears next cycle and the partial frame is dropped. The next frame must start at (0,0), either by counter position or by sof. A stale line buffer is never read because an even row always precedes its odd row.
- Frame wrap: after the last pixel (IN_HEIGHT-1, IN_WIDTH-1), the next accepted pixel is (0,0) with no dead cycle.

Test Plan:
1. Full 800x600 frame, constant pixel 100, valid always high -> exactly 120000 validout pulses, all dataout=100. sof_out is high only on the first pulse, which occurs 1 cycle after input (1,1) is accepted.
2. Block (0,0)=10, (0,1)=20, (1,0)=30, (1,1)=41 -> first dataout=25 ((101+2)>>2). Block values 1,1,1,2 -> 1. Block values 1,1,2,2 -> 2 (half-up rounding).
3. All pixels 255 -> every dataout=255, with no wrap to 0. All pixels 0 -> every dataout=0.
4. Random gradient frame with valid toggled randomly (~50% duty) -> output sequence identical to the gapless run of the same frame. Pulse count is 120000 and latency is 1 cycle from each accepted odd/odd pixel.
5. sof asserted with valid at input (row 3, col 17) mid-frame -> counters restart; the following 800x600 frame yields 120000 correct outputs, and sof_out marks its first output.
6. One-cycle reset asserted at (row 1, col 400) -> validout=0 the next cycle. The following frame starting with sof yields the correct first output, and no value derived from the interrupted row appears.
